// File: rtl/axi_sram_slave.sv
// ----------------------------------------------------------------------------
// axi_sram_slave
//   AXI-style SRAM slave with independent write and read channels. It supports
//   INCR bursts of 32-bit words only; address bits [1:0] are ignored. The
//   memory lives at BASE .. BASE+4*DEPTH-1. Beats outside that window return
//   SLVERR. Out-of-range writes are dropped and out-of-range reads return zero.
//
// Parameters
//   BASE    byte address of memory word 0
//   DEPTH   memory size in 32-bit words
//   RD_LAT  wait cycles between the AR handshake and the first read beat (0 ok)
//
// Ports
//   clock, reset                  single clock, async active-high reset
//   io_slave_aw*                  write address channel (valid/ready/addr/id/len)
//   io_slave_w*                   write data channel (valid/ready/data/strb/last)
//   io_slave_b*                   write response channel (valid/ready/resp/id)
//   io_slave_ar*                  read address channel (valid/ready/addr/id/len)
//   io_slave_r*                   read data channel (valid/ready/data/resp/last/id)
// ----------------------------------------------------------------------------
module axi_sram_slave #(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    // write address
    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    // write data
    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    // write response
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    // read address
    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    // read data
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [31:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // 33 bits so that a window ending at 4 GiB does not wrap to zero
    localparam logic [32:0] END_ADDR = {1'b0, BASE} + (33'(DEPTH) * 33'd4);
    localparam logic [7:0]  LAT_LAST = (RD_LAT > 0) ? 8'(RD_LAT - 1) : 8'd0;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    function automatic logic f_in_range(input logic [31:0] a);
        return (a >= BASE) && ({1'b0, a} < END_ADDR);
    endfunction

    function automatic logic [AW-1:0] f_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[AW+1:2];
    endfunction

    logic [31:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t    r_wstate;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic [3:0]  r_wid;
    logic [31:0] r_waddr;
    logic [7:0]  r_wlen;
    logic [7:0]  r_wbeat;
    logic        r_werr;

    logic w_w_fire;
    logic w_w_in;
    logic w_w_final;
    logic w_w_beat_err;

    assign w_w_fire     = r_wready & io_slave_wvalid;
    assign w_w_in       = f_in_range(r_waddr);
    assign w_w_final    = (r_wbeat == r_wlen);
    // a beat is bad if it misses the window or its wlast disagrees with the count
    assign w_w_beat_err = ~w_w_in | (io_slave_wlast != w_w_final);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wid     <= 4'h0;
            r_waddr   <= 32'h0;
            r_wlen    <= 8'h0;
            r_wbeat   <= 8'h0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (r_awready && io_slave_awvalid) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_waddr   <= io_slave_awaddr;
                        r_wid     <= io_slave_awid;
                        r_wlen    <= io_slave_awlen;
                        r_wbeat   <= 8'h0;
                        r_werr    <= 1'b0;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_fire) begin
                        r_waddr <= r_waddr + 32'd4;
                        r_wbeat <= r_wbeat + 8'd1;
                        if (w_w_beat_err) begin
                            r_werr <= 1'b1;
                        end
                        if (w_w_final) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr || w_w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (io_slave_bready) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Memory has no reset; wready is low during reset so nothing is written.
    always_ff @(posedge clock) begin
        if (w_w_fire && w_w_in) begin
            for (int b = 0; b < 4; b++) begin
                if (io_slave_wstrb[b]) begin
                    r_mem[f_index(r_waddr)][8*b +: 8] <= io_slave_wdata[8*b +: 8];
                end
            end
        end
    end

    assign io_slave_awready = r_awready;
    assign io_slave_wready  = r_wready;
    assign io_slave_bvalid  = r_bvalid;
    assign io_slave_bresp   = r_bresp;
    assign io_slave_bid     = r_wid;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    r_state_t    r_rstate;
    logic        r_arready;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;
    logic        r_rlast;
    logic [3:0]  r_rid;
    logic [31:0] r_raddr;
    logic [7:0]  r_rlen;
    logic [7:0]  r_rbeat;
    logic [7:0]  r_lat_cnt;

    // Address and last flag of the beat that is loaded into the output registers
    // on the next edge. rdata is captured from the array, so a same-cycle write
    // to that word is seen only by later reads.
    logic [31:0] w_f_addr;
    logic        w_f_last;
    logic        w_f_in;
    logic [31:0] w_f_data;

    always_comb begin
        w_f_addr = r_raddr;
        w_f_last = (r_rlen == 8'h0);
        if (r_rstate == R_IDLE) begin
            w_f_addr = io_slave_araddr;
            w_f_last = (io_slave_arlen == 8'h0);
        end else if (r_rstate == R_DATA) begin
            w_f_addr = r_raddr + 32'd4;
            w_f_last = ((r_rbeat + 8'd1) == r_rlen);
        end
    end

    assign w_f_in   = f_in_range(w_f_addr);
    assign w_f_data = w_f_in ? r_mem[f_index(w_f_addr)] : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= 32'h0;
            r_rlast   <= 1'b0;
            r_rid     <= 4'h0;
            r_raddr   <= 32'h0;
            r_rlen    <= 8'h0;
            r_rbeat   <= 8'h0;
            r_lat_cnt <= 8'h0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_arready && io_slave_arvalid) begin
                        r_arready <= 1'b0;
                        r_raddr   <= io_slave_araddr;
                        r_rid     <= io_slave_arid;
                        r_rlen    <= io_slave_arlen;
                        r_rbeat   <= 8'h0;
                        r_lat_cnt <= 8'h0;
                        if (RD_LAT == 0) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_f_data;
                            r_rresp  <= w_f_in ? RESP_OKAY : RESP_SLVERR;
                            r_rlast  <= w_f_last;
                            r_rstate <= R_DATA;
                        end else begin
                            r_rstate <= R_WAIT;
                        end
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_f_data;
                        r_rresp  <= w_f_in ? RESP_OKAY : RESP_SLVERR;
                        r_rlast  <= w_f_last;
                        r_rstate <= R_DATA;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 8'd1;
                    end
                end
                R_DATA: begin
                    if (io_slave_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rresp   <= RESP_OKAY;
                            r_rdata   <= 32'h0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr <= r_raddr + 32'd4;
                            r_rbeat <= r_rbeat + 8'd1;
                            r_rdata <= w_f_data;
                            r_rresp <= w_f_in ? RESP_OKAY : RESP_SLVERR;
                            r_rlast <= w_f_last;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign io_slave_arready = r_arready;
    assign io_slave_rvalid  = r_rvalid;
    assign io_slave_rresp   = r_rresp;
    assign io_slave_rdata   = r_rdata;
    assign io_slave_rlast   = r_rlast;
    assign io_slave_rid     = r_rid;

endmodule
